// File: rtl/simpu_pkg.sv
// Shared definitions for the simple CPU front end: the HALT opcode and the fetch FSM states.
package simpu_pkg;

  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } fetch_state_t;

  function automatic logic is_halt_word(input logic [5:0] opcode);
    return opcode == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter: reset value, +1 increment with natural wrap, redirect load taking priority.
module fetch_pc #(
  parameter int unsigned          ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (i_redirect) begin
      r_pc <= i_redirect_pc;
    end else if (i_inc) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register with valid/ready handoff, redirect and HALT.
// Optional out-of-range fetch trap enabled by defining FETCH_BOUND_CHECK_EN.
module fetch_unit
  import simpu_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       MEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
  output logic              fault
);

`ifdef FETCH_BOUND_CHECK_EN
  localparam logic BOUND_CHECK = 1'b1;
`else
  localparam logic BOUND_CHECK = 1'b0;
`endif
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_DEPTH);

  fetch_state_t      r_state;
  logic [DATA_W-1:0] r_inst_out;
  logic [ADDR_W-1:0] r_inst_pc;
  logic              r_inst_valid;
  logic              r_fault;

  logic [ADDR_W-1:0] w_pc;
  logic              w_redirect;
  logic              w_can_load;
  logic              w_oob;
  logic              w_load;
  logic              w_fault_evt;
  logic              w_halt_word;

  // Redirect outranks everything, so a word offered in the same cycle is never loaded.
  assign w_redirect  = redirect_valid && (r_state != IDLE);
  assign w_can_load  = (r_state == RUN) && (!r_inst_valid || inst_ready) && !w_redirect;
  assign w_oob       = BOUND_CHECK && ({1'b0, w_pc} >= MEM_LIMIT);
  assign w_load      = w_can_load && !w_oob;
  assign w_fault_evt = w_can_load && w_oob;
  assign w_halt_word = is_halt_word(imem_data[DATA_W-1 -: 6]);

  fetch_pc #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk          (clk),
    .reset        (reset),
    .i_redirect   (w_redirect),
    .i_redirect_pc(redirect_pc),
    .i_inc        (w_load && !w_halt_word),
    .o_pc         (w_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_inst_out   <= '0;
      r_inst_pc    <= '0;
      r_inst_valid <= 1'b0;
      r_fault      <= 1'b0;
    end else if (w_redirect) begin
      r_inst_valid <= 1'b0;
      r_state      <= RUN;
    end else if (w_load) begin
      r_inst_out   <= imem_data;
      r_inst_pc    <= w_pc;
      r_inst_valid <= 1'b1;
      if (w_halt_word) r_state <= HALT;
    end else if (w_fault_evt) begin
      r_inst_valid <= 1'b0;
      r_fault      <= 1'b1;
      r_state      <= HALT;
    end else begin
      if (r_inst_valid && inst_ready) r_inst_valid <= 1'b0;
      if ((r_state == IDLE) && start) r_state <= RUN;
    end
  end

  assign imem_addr  = w_pc;
  assign inst_out   = r_inst_out;
  assign inst_pc    = r_inst_pc;
  assign inst_valid = r_inst_valid;
  assign halted     = (r_state == HALT);
  assign fault      = r_fault;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly downstream of the instruction memory: it owns the program counter, drives the memory's read address, and captures the combinationally read 32-bit word into an instruction register. That register is presented to decode over a valid/ready handshake. The stage supports branch redirect with flush, stall under backpressure, and a halt state entered when a HALT opcode is fetched.

## Interface
- ADDR_W, 16, PC / memory address width
- DATA_W, 32, instruction width
- MEM_DEPTH, 256, number of implemented memory words (used only with bound checking)
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  leave IDLE and begin fetching
- imem_addr  out  ADDR_W  read address to instruction memory (= pc)
- imem_data  in  DATA_W  combinational read data for imem_addr
- inst_out  out  DATA_W  held instruction
- inst_pc  out  ADDR_W  address inst_out was fetched from
- inst_valid  out  1  inst_out is valid
- inst_ready  in  1  decode accepts inst_out this cycle
- redirect_valid  in  1  branch/jump taken; flush and load redirect_pc
- redirect_pc  in  ADDR_W  new fetch address
- halted  out  1  state is HALT
- fault  out  1  out-of-range fetch (sticky until reset)

## Operation
- Reset values: pc=RESET_PC, inst_out=0, inst_pc=0, inst_valid=0, halted=0, fault=0, state=IDLE. Asserting reset mid-operation discards any held instruction immediately.
- States: IDLE, RUN, HALT.
  - IDLE -> RUN when start=1.
  - RUN -> HALT when a HALT word is loaded, or on a bound fault.
  - HALT -> RUN only on redirect_valid.
- Advance condition in RUN: `load = !inst_valid || inst_ready`.
- On load: inst_out<=imem_data, inst_pc<=pc, inst_valid<=1, pc<=pc+1.
- The PC is ADDR_W bits and wraps 0xFFFF -> 0x0000.
- Transfer: the instruction is consumed in any cycle where inst_valid && inst_ready.
  - If load does not occur in the same cycle, inst_valid<=0.
  - Back-to-back transfers give one instruction per cycle.
- Stall: with inst_valid=1 and inst_ready=0, inst_out, inst_pc and pc hold.
- HALT word: imem_data[31:26]==HALT_OPCODE.
  - The HALT word is loaded and delivered like any instruction.
  - The PC does not increment; state becomes HALT.
  - No further loads occur; the held word is still handed off normally.
- Redirect has highest priority in every state except IDLE (ignored there).
  - pc<=redirect_pc; inst_valid<=0, so a held or simultaneously offered word is dropped.
  - No load occurs that cycle; state becomes RUN.
  - Redirect in the same cycle as a HALT word being offered: the redirect wins and the HALT word is discarded.
- start while in RUN or HALT: no effect.

## Timing
- imem_addr equals pc combinationally; the memory read is combinational.
- Fetch latency is 1 cycle: pc presented in cycle N, inst_valid with that word in cycle N+1.
- Redirect-to-valid latency is 2 cycles: redirect in cycle N, pc updated at N+1, word valid at N+2.
- The first instruction after start is valid 2 cycles after the start cycle.
- halted asserts in the cycle after the HALT word is loaded.

## Configuration
- FETCH_BOUND_CHECK_EN defined:
  - When load would occur with pc >= MEM_DEPTH, nothing is loaded.
  - fault<=1, state<=HALT, inst_valid<=0.
  - Recovery requires a redirect; fault stays 1 until reset.
- Undefined: no range check; fault is tied 0 and the PC wraps freely at 2^ADDR_W.

## Structure
- Shared package simpu_pkg:
  - HALT_OPCODE = 6'b111111;
  - fetch_state_t enum {IDLE, RUN, HALT}.
- Sub-module fetch_pc holds the PC register with reset, increment, redirect priority and wrap. The FSM, instruction register and handshake stay in fetch_unit.

## Test plan
- Start and stream: memory words 0..2 = 0x6842000A, 0x6885FFF0, 0x48C81100; start, inst_ready=1 -> inst_out sequence 0x6842000A/pc0, 0x6885FFF0/pc1, 0x48C81100/pc2 on consecutive cycles from start+2.
- Backpressure: inst_ready=0 for 3 cycles while valid at pc1 -> inst_out, inst_pc=1 and pc=2 held; the release cycle transfers pc1 and the next cycle shows pc2.
- Redirect flush: redirect_valid with redirect_pc=0x0040 while pc1 is held -> inst_valid=0 next cycle; inst_pc=0x0040 valid 2 cycles after the redirect.
- Halt: word 0xFC000000 at pc3 -> delivered with inst_pc=3, halted=1, no further valid; a later redirect to 0 resumes with pc0.
- Wrap and bounds: redirect to 0xFFFF.
  - With FETCH_BOUND_CHECK_EN undefined -> word at 0xFFFF delivered, then pc0.
  - With it defined and MEM_DEPTH=256 -> fault=1, halted=1, inst_valid=0.
- Async reset mid-stream: reset asserted between clock edges while valid -> inst_valid=0, pc=RESET_PC immediately; state IDLE until start.
